// File: rtl/fetch_unit_if.sv
// -----------------------------------------------------------------------------
// fetch_unit_if
//   Bundles every signal exchanged between the fetch stage and the rest of the
//   pipeline (hazard unit, D-stage branch logic, CP0, instruction memory).
//   Clock and reset stay outside the interface as plain module ports.
//
//   Modports
//     master : pipeline side; drives the control/redirect inputs and F_instr,
//              observes the fetch address and the F/D register.
//     slave  : the fetch unit itself.
//
//   Signals
//     stall      hazard stall, hold PC and F/D register
//     req        exception/interrupt request from CP0
//     eret       eret decoded in D
//     epc        return address from CP0
//     if_branch  branch taken, from the D-stage comparator
//     D_jump     D holds j/jal
//     D_jr       D holds jr/jalr
//     D_is_bj    D holds any branch/jump (next fetch is a delay slot)
//     D_rs       forwarded rs value (jr target)
//     F_instr    instruction word read from IM at F_pc
//     F_pc       current fetch address
//     D_instr    registered instruction
//     D_pc       registered PC of D_instr
//     D_bd       D_instr sits in a branch delay slot
//     D_exc      fetch exception code (0 = none, 4 = AdEL)
// -----------------------------------------------------------------------------
interface fetch_unit_if;
    logic        stall;
    logic        req;
    logic        eret;
    logic [31:0] epc;
    logic        if_branch;
    logic        D_jump;
    logic        D_jr;
    logic        D_is_bj;
    logic [31:0] D_rs;
    logic [31:0] F_instr;
    logic [31:0] F_pc;
    logic [31:0] D_instr;
    logic [31:0] D_pc;
    logic        D_bd;
    logic [4:0]  D_exc;

    modport master (
        output stall, req, eret, epc, if_branch, D_jump, D_jr, D_is_bj, D_rs, F_instr,
        input  F_pc, D_instr, D_pc, D_bd, D_exc
    );

    modport slave (
        input  stall, req, eret, epc, if_branch, D_jump, D_jr, D_is_bj, D_rs, F_instr,
        output F_pc, D_instr, D_pc, D_bd, D_exc
    );
endinterface

// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//   Fetch stage of the P7 five-stage MIPS pipeline. Holds the PC, chooses the
//   next PC (reset, exception entry, eret, stall, branch, j, jr, sequential)
//   and registers the F->D pipeline register (D_instr, D_pc, D_bd, D_exc).
//
//   Ports
//     clk    : clock, every state update on the rising edge
//     reset  : synchronous, active-high
//     bus    : fetch_unit_if.slave, all pipeline/CP0/IM signals
//
//   Configuration macro
//     FETCH_ADEL_CHECK_EN : when defined, a misaligned fetch address or one
//                           outside [IM_BASE, IM_TOP] raises AdEL (code 4) and
//                           the fetched word is replaced by 0. When undefined
//                           the fetch code is always 0 and F_instr passes
//                           through unchanged.
// -----------------------------------------------------------------------------
module fetch_unit #(
    parameter logic [31:0] PC_RESET  = 32'h0000_3000,
    parameter logic [31:0] EXC_ENTRY = 32'h0000_4180
`ifdef FETCH_ADEL_CHECK_EN
    ,
    // The legal fetch window only exists when the address check is built.
    parameter logic [31:0] IM_BASE   = 32'h0000_3000,
    parameter logic [31:0] IM_TOP    = 32'h0000_6ffc
`endif
) (
    input  logic          clk,
    input  logic          reset,
    fetch_unit_if.slave   bus
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

    logic [31:0] r_fPc;
    logic [31:0] r_dInstr;
    logic [31:0] r_dPc;
    logic        r_dBd;
    logic [4:0]  r_dExc;

    logic [31:0] w_pcPlus4;
    logic [31:0] w_branchTarget;
    logic [31:0] w_jumpTarget;
    logic [4:0]  w_fetchExc;
    logic [31:0] w_fetchedInstr;

    // Redirect targets are built from the instruction frozen in D, so a stall
    // simply re-evaluates the same decision on the next cycle.
    assign w_pcPlus4      = r_fPc + 32'd4;
    assign w_branchTarget = r_dPc + 32'd4 + {{14{r_dInstr[15]}}, r_dInstr[15:0], 2'b00};
    assign w_jumpTarget   = {r_dPc[31:28], r_dInstr[25:0], 2'b00};

`ifdef FETCH_ADEL_CHECK_EN
    logic w_addrBad;

    assign w_addrBad  = (r_fPc[1:0] != 2'b00) || (r_fPc < IM_BASE) || (r_fPc > IM_TOP);
    assign w_fetchExc = w_addrBad ? EXC_ADEL : EXC_NONE;
`else
    assign w_fetchExc = EXC_NONE;
`endif

    // A faulting fetch enters D as a nop; D_pc still records the bad address.
    assign w_fetchedInstr = (w_fetchExc != EXC_NONE) ? 32'd0 : bus.F_instr;

    // PC and F/D register share one priority chain: reset, exception entry,
    // eret (only when not stalled), stall hold, then the normal advance.
    // Exception entry and eret both insert a bubble that already carries the
    // new PC, so CP0 never samples a stale D_pc. eret has no delay slot, so
    // the word fetched alongside it is discarded.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fPc    <= PC_RESET;
            r_dInstr <= 32'd0;
            r_dPc    <= PC_RESET;
            r_dBd    <= 1'b0;
            r_dExc   <= EXC_NONE;
        end else if (bus.req) begin
            r_fPc    <= EXC_ENTRY;
            r_dInstr <= 32'd0;
            r_dPc    <= EXC_ENTRY;
            r_dBd    <= 1'b0;
            r_dExc   <= EXC_NONE;
        end else if (bus.eret && !bus.stall) begin
            r_fPc    <= bus.epc;
            r_dInstr <= 32'd0;
            r_dPc    <= bus.epc;
            r_dBd    <= 1'b0;
            r_dExc   <= EXC_NONE;
        end else if (!bus.stall) begin
            if (bus.if_branch) begin
                r_fPc <= w_branchTarget;
            end else if (bus.D_jump) begin
                r_fPc <= w_jumpTarget;
            end else if (bus.D_jr) begin
                r_fPc <= bus.D_rs;
            end else begin
                r_fPc <= w_pcPlus4;
            end
            // The word being fetched now is the delay slot of whatever sits
            // in D, so it is never squashed and inherits D_is_bj as its flag.
            r_dInstr <= w_fetchedInstr;
            r_dPc    <= r_fPc;
            r_dBd    <= bus.D_is_bj;
            r_dExc   <= w_fetchExc;
        end
    end

    assign bus.F_pc    = r_fPc;
    assign bus.D_instr = r_dInstr;
    assign bus.D_pc    = r_dPc;
    assign bus.D_bd    = r_dBd;
    assign bus.D_exc   = r_dExc;

endmodule

// File: tb/tb_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_fetch_unit
//   Directed, table-driven bench for fetch_unit. Each table row holds the
//   inputs for one rising edge and the expected F_pc / F-D register after it.
//   A hand-written sequence afterwards covers a long stall with a pending
//   branch. Expected fetch-exception results follow FETCH_ADEL_CHECK_EN.
// -----------------------------------------------------------------------------
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    fetch_unit_if bus ();

    fetch_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef FETCH_ADEL_CHECK_EN
    localparam bit ADEL = 1'b1;
`else
    localparam bit ADEL = 1'b0;
`endif
    localparam logic [4:0] BAD_EXC = ADEL ? 5'd4 : 5'd0;

    typedef struct {
        logic        rst;
        logic        stall;
        logic        req;
        logic        eret;
        logic [31:0] epc;
        logic        br;
        logic        jmp;
        logic        jr;
        logic        isBj;
        logic [31:0] rs;
        logic [31:0] instr;
        logic [31:0] expFPc;
        logic [31:0] expDInstr;
        logic [31:0] expDPc;
        logic        expDBd;
        logic [4:0]  expDExc;
    } vec_t;

    vec_t vecs[$];
    int   compared   = 0;
    int   mismatched = 0;

    // Word expected in D after fetching from an illegal address.
    function automatic logic [31:0] badWord(input logic [31:0] w);
        return ADEL ? 32'd0 : w;
    endfunction

    task automatic addVec(
        input logic rst, stall, req, eret, input logic [31:0] epc,
        input logic br, jmp, jr, isBj, input logic [31:0] rs, instr,
        input logic [31:0] eFPc, eDInstr, eDPc, input logic eBd, input logic [4:0] eExc);
        vec_t v;
        v.rst = rst; v.stall = stall; v.req = req; v.eret = eret; v.epc = epc;
        v.br = br; v.jmp = jmp; v.jr = jr; v.isBj = isBj; v.rs = rs; v.instr = instr;
        v.expFPc = eFPc; v.expDInstr = eDInstr; v.expDPc = eDPc;
        v.expDBd = eBd; v.expDExc = eExc;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input vec_t v);
        reset         = v.rst;
        bus.stall     = v.stall;
        bus.req       = v.req;
        bus.eret      = v.eret;
        bus.epc       = v.epc;
        bus.if_branch = v.br;
        bus.D_jump    = v.jmp;
        bus.D_jr      = v.jr;
        bus.D_is_bj   = v.isBj;
        bus.D_rs      = v.rs;
        bus.F_instr   = v.instr;
    endtask

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic checkOutput(input string tag, input vec_t v);
        checkVal({tag, " F_pc"},    bus.F_pc,            v.expFPc);
        checkVal({tag, " D_instr"}, bus.D_instr,         v.expDInstr);
        checkVal({tag, " D_pc"},    bus.D_pc,            v.expDPc);
        checkVal({tag, " D_bd"},    {31'd0, bus.D_bd},   {31'd0, v.expDBd});
        checkVal({tag, " D_exc"},   {27'd0, bus.D_exc},  {27'd0, v.expDExc});
    endtask

    initial begin
        vec_t v;

        //     rst st rq er epc         br jm jr bj rs          instr        | F_pc         D_instr               D_pc         bd exc
        addVec(1, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h0,        32'h3000, 32'h0,                32'h3000, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h11111111, 32'h3004, 32'h11111111,         32'h3000, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h22222222, 32'h3008, 32'h22222222,         32'h3004, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h1000fffe, 32'h300c, 32'h1000fffe,         32'h3008, 0, 5'd0);
        // branch back by 2 words beats simultaneous jump/jr; slot gets D_bd
        addVec(0, 0, 0, 0, 32'h0,      1, 1, 1, 1, 32'h5000,   32'h33333333, 32'h3004, 32'h33333333,         32'h300c, 1, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h22222222, 32'h3008, 32'h22222222,         32'h3004, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h44444444, 32'h300c, 32'h44444444,         32'h3008, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h55555555, 32'h3010, 32'h55555555,         32'h300c, 0, 5'd0);
        // three stalled cycles, including branch+stall and eret+stall
        addVec(0, 1, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h66666666, 32'h3010, 32'h55555555,         32'h300c, 0, 5'd0);
        addVec(0, 1, 0, 0, 32'h0,      1, 0, 0, 1, 32'h0,      32'h66666666, 32'h3010, 32'h55555555,         32'h300c, 0, 5'd0);
        addVec(0, 1, 0, 1, 32'h3020,   0, 0, 0, 0, 32'h0,      32'h66666666, 32'h3010, 32'h55555555,         32'h300c, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h66666666, 32'h3014, 32'h66666666,         32'h3010, 0, 5'd0);
        // req beats stall and eret
        addVec(0, 1, 1, 1, 32'h3020,   0, 0, 0, 1, 32'h0,      32'h66666666, 32'h4180, 32'h0,                32'h4180, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h77777777, 32'h4184, 32'h77777777,         32'h4180, 0, 5'd0);
        // eret beats branch, nullifies fetched word
        addVec(0, 0, 0, 1, 32'h3020,   1, 0, 0, 0, 32'h0,      32'h88888888, 32'h3020, 32'h0,                32'h3020, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h99999999, 32'h3024, 32'h99999999,         32'h3020, 0, 5'd0);
        // jr to a misaligned address
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 1, 1, 32'h3002,   32'haaaaaaaa, 32'h3002, 32'haaaaaaaa,         32'h3024, 1, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'hbbbbbbbb, 32'h3006, badWord(32'hbbbbbbbb), 32'h3002, 0, BAD_EXC);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 1, 1, 32'h3ff8,   32'hcccccccc, 32'h3ff8, badWord(32'hcccccccc), 32'h3006, 1, BAD_EXC);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'hdddddddd, 32'h3ffc, 32'hdddddddd,         32'h3ff8, 0, 5'd0);
        // j with index 0x0001000 from D_pc 0x3ffc
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h08001000, 32'h4000, 32'h08001000,         32'h3ffc, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 1, 1, 1, 32'h5000,   32'heeeeeeee, 32'h4000, 32'heeeeeeee,         32'h4000, 1, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'hffffffff, 32'h4004, 32'hffffffff,         32'h4000, 0, 5'd0);
        // just above the IM window
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 1, 0, 32'h7000,   32'h12345678, 32'h7000, 32'h12345678,         32'h4004, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h13579bdf, 32'h7004, badWord(32'h13579bdf), 32'h7000, 0, BAD_EXC);
        // reset beats stall and req
        addVec(1, 1, 1, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h0,        32'h3000, 32'h0,                32'h3000, 0, 5'd0);
        // top of the IM window is legal, below the base is not
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 1, 0, 32'h6ffc,   32'h01010101, 32'h6ffc, 32'h01010101,         32'h3000, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h02020202, 32'h7000, 32'h02020202,         32'h6ffc, 0, 5'd0);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 1, 0, 32'h2ffc,   32'h03030303, 32'h2ffc, badWord(32'h03030303), 32'h7000, 0, BAD_EXC);
        addVec(0, 0, 0, 0, 32'h0,      0, 0, 0, 0, 32'h0,      32'h04040404, 32'h3000, badWord(32'h04040404), 32'h2ffc, 0, BAD_EXC);

        @(negedge clk);
        foreach (vecs[i]) begin
            applyStimulus(vecs[i]);
            @(posedge clk);
            #1;
            checkOutput($sformatf("row%0d", i), vecs[i]);
            @(negedge clk);
        end

        // Long stall with a taken branch waiting in D: reset, load a branch
        // with imm=3 at 0x3000, hold for four cycles, then release.
        v = '{rst: 1'b1, stall: 1'b0, req: 1'b0, eret: 1'b0, epc: 32'h0, br: 1'b0,
              jmp: 1'b0, jr: 1'b0, isBj: 1'b0, rs: 32'h0, instr: 32'h0,
              expFPc: 32'h3000, expDInstr: 32'h0, expDPc: 32'h3000, expDBd: 1'b0, expDExc: 5'd0};
        applyStimulus(v);
        @(posedge clk); #1;
        checkOutput("seqReset", v);
        @(negedge clk);

        v.rst = 1'b0; v.instr = 32'h10000003;
        v.expFPc = 32'h3004; v.expDInstr = 32'h10000003; v.expDPc = 32'h3000;
        applyStimulus(v);
        @(posedge clk); #1;
        checkOutput("seqLoad", v);
        @(negedge clk);

        for (int k = 0; k < 4; k++) begin
            v.stall = 1'b1; v.br = 1'b1; v.isBj = 1'b1; v.instr = $urandom;
            applyStimulus(v);
            @(posedge clk); #1;
            checkOutput($sformatf("seqStall%0d", k), v);
            @(negedge clk);
        end

        v.stall = 1'b0; v.instr = 32'h5a5a5a5a;
        v.expFPc = 32'h3010; v.expDInstr = 32'h5a5a5a5a; v.expDPc = 32'h3004; v.expDBd = 1'b1;
        applyStimulus(v);
        @(posedge clk); #1;
        checkOutput("seqRelease", v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
